// File: rtl/spram_uart_reader_if.sv
// ---------------------------------------------------------------------------
// spram_uart_reader_if
// Groups the SPRAM read port and the UART transmit handshake used by
// spram_uart_reader.
//   master : the reader (drives ram_addr/ram_wren/tx_data/tx_send)
//   slave  : the SPRAM + UART side (drives ram_data_out/tx_ready)
// Signals:
//   ram_addr     SPRAM word address
//   ram_wren     SPRAM write enable (always 0 from the reader)
//   ram_data_out SPRAM read data
//   tx_data      byte offered to the transmitter
//   tx_send      tx_data is valid
//   tx_ready     transmitter accepts; a byte moves on a clk edge with
//                tx_send=1 and tx_ready=1
// ---------------------------------------------------------------------------
interface spram_uart_reader_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_wren;
   logic [DATA_WIDTH-1:0] ram_data_out;
   logic [7:0]            tx_data;
   logic                  tx_send;
   logic                  tx_ready;

   modport master (
      output ram_addr,
      output ram_wren,
      output tx_data,
      output tx_send,
      input  ram_data_out,
      input  tx_ready
   );

   modport slave (
      input  ram_addr,
      input  ram_wren,
      input  tx_data,
      input  tx_send,
      output ram_data_out,
      output tx_ready
   );
endinterface

// File: rtl/spram_uart_reader.sv
// ---------------------------------------------------------------------------
// spram_uart_reader
// Reads word_count 16-bit words from SPRAM starting at base_addr and streams
// them to a UART transmitter, high byte first. Addresses wrap modulo
// 2^ADDR_WIDTH.
//
// Optional build macro: CHECKSUM_EN
//   When defined, one extra byte (XOR of every data byte of the dump, 0x00
//   for an empty dump) is sent after the last word, before done.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start       one-cycle dump request, ignored while busy
//   base_addr   first word address, sampled with start
//   word_count  number of words (0 .. 2^ADDR_WIDTH), sampled with start
//   busy        dump in progress
//   done        one-cycle pulse after the last byte has been accepted
//   bus         spram_uart_reader_if.master: SPRAM port + UART handshake
// ---------------------------------------------------------------------------
module spram_uart_reader #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 16,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   word_count,
   output logic                  busy,
   output logic                  done,
   spram_uart_reader_if.master   bus
);

   localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   // Value of lat_cnt_r on the edge where the SPRAM data becomes valid.
   localparam logic [1:0]            LAT_LAST = 2'(READ_LATENCY - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_SEND_HI = 3'd3,
      ST_SEND_LO = 3'd4,
      ST_SEND_CK = 3'd5,
      ST_FINISH  = 3'd6
   } state_t;

   state_t                state_r;
   logic [ADDR_WIDTH-1:0] ram_addr_r;
   logic [ADDR_WIDTH:0]   remaining_r;
   logic [7:0]            lo_byte_r;
   logic [1:0]            lat_cnt_r;
   logic [7:0]            tx_data_r;
   logic                  tx_send_r;
   logic                  busy_r;
   logic                  done_r;

`ifdef CHECKSUM_EN
   logic [7:0]            csum_r;

   // XOR of the two bytes of one SPRAM word.
   function automatic logic [7:0] fold_xor(input logic [DATA_WIDTH-1:0] w);
      return w[DATA_WIDTH-1 -: 8] ^ w[7:0];
   endfunction
`endif

   // Output mapping: every output comes straight from a register.
   assign busy         = busy_r;
   assign done         = done_r;
   assign bus.ram_addr = ram_addr_r;
   assign bus.ram_wren = 1'b0;
   assign bus.tx_data  = tx_data_r;
   assign bus.tx_send  = tx_send_r;

   // Dump sequencer: address/latency tracking, byte handshake, done/busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         ram_addr_r  <= {ADDR_WIDTH{1'b0}};
         remaining_r <= CNT_ZERO;
         lo_byte_r   <= 8'h00;
         lat_cnt_r   <= 2'd0;
         tx_data_r   <= 8'h00;
         tx_send_r   <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
`ifdef CHECKSUM_EN
         csum_r      <= 8'h00;
`endif
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  ram_addr_r  <= base_addr;
                  remaining_r <= word_count;
                  lat_cnt_r   <= 2'd0;
                  busy_r      <= 1'b1;
`ifdef CHECKSUM_EN
                  csum_r <= 8'h00;
                  if (word_count == CNT_ZERO) begin
                     // Empty dump still sends the (zero) checksum byte.
                     tx_data_r <= 8'h00;
                     tx_send_r <= 1'b1;
                     state_r   <= ST_SEND_CK;
                  end else begin
                     state_r <= ST_FETCH;
                  end
`else
                  if (word_count == CNT_ZERO) begin
                     state_r <= ST_FINISH;
                  end else begin
                     state_r <= ST_FETCH;
                  end
`endif
               end else begin
                  state_r <= ST_IDLE;
               end
            end

            ST_FETCH: begin
               if (READ_LATENCY <= 1) begin
                  // Data already valid on the first edge after the address.
                  lo_byte_r <= bus.ram_data_out[7:0];
                  tx_data_r <= bus.ram_data_out[DATA_WIDTH-1 -: 8];
                  tx_send_r <= 1'b1;
`ifdef CHECKSUM_EN
                  csum_r    <= csum_r ^ fold_xor(bus.ram_data_out);
`endif
                  state_r   <= ST_SEND_HI;
               end else begin
                  lat_cnt_r <= 2'd1;
                  state_r   <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (lat_cnt_r == LAT_LAST) begin
                  lo_byte_r <= bus.ram_data_out[7:0];
                  tx_data_r <= bus.ram_data_out[DATA_WIDTH-1 -: 8];
                  tx_send_r <= 1'b1;
`ifdef CHECKSUM_EN
                  csum_r    <= csum_r ^ fold_xor(bus.ram_data_out);
`endif
                  state_r   <= ST_SEND_HI;
               end else begin
                  lat_cnt_r <= lat_cnt_r + 2'd1;
               end
            end

            ST_SEND_HI: begin
               // tx_send stays high into SEND_LO; only tx_data changes.
               if (bus.tx_ready) begin
                  tx_data_r <= lo_byte_r;
                  state_r   <= ST_SEND_LO;
               end else begin
                  state_r <= ST_SEND_HI;
               end
            end

            ST_SEND_LO: begin
               if (bus.tx_ready) begin
                  remaining_r <= remaining_r - CNT_ONE;
                  ram_addr_r  <= ram_addr_r + ADDR_ONE;
                  if (remaining_r == CNT_ONE) begin
`ifdef CHECKSUM_EN
                     tx_data_r <= csum_r;
                     state_r   <= ST_SEND_CK;
`else
                     tx_send_r <= 1'b0;
                     state_r   <= ST_FINISH;
`endif
                  end else begin
                     tx_send_r <= 1'b0;
                     state_r   <= ST_FETCH;
                  end
               end else begin
                  state_r <= ST_SEND_LO;
               end
            end

`ifdef CHECKSUM_EN
            ST_SEND_CK: begin
               if (bus.tx_ready) begin
                  tx_send_r <= 1'b0;
                  state_r   <= ST_FINISH;
               end else begin
                  state_r <= ST_SEND_CK;
               end
            end
`endif

            ST_FINISH: begin
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end

            default: begin
               tx_send_r <= 1'b0;
               busy_r    <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spram_uart_reader.sv
// ---------------------------------------------------------------------------
// tb_spram_uart_reader
// Randomised and directed dumps against a byte-list reference model. The
// stimulus side pushes every byte a dump must produce into exp_q; a monitor
// pops and compares whenever a byte transfers.
// ---------------------------------------------------------------------------
module tb_spram_uart_reader;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int RL = 2;
`ifdef CHECKSUM_EN
   localparam int CK_BYTES = 1;
`else
   localparam int CK_BYTES = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   word_count = '0;
   logic          busy;
   logic          done;

   spram_uart_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   spram_uart_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // SPRAM model: data for an address is valid RL-1 registered stages later,
   // so the reader samples it on the RL-th edge after the address change.
   logic [DW-1:0] mem [0:65535];
   logic [DW-1:0] ram_q;
   always @(posedge clk) ram_q <= mem[bus.ram_addr];
   assign bus.ram_data_out = ram_q;

   int         vectors = 0;
   int         miscompares = 0;
   int         done_cnt = 0;
   int         exp_dones = 0;
   bit         stim_done = 1'b0;
   logic [7:0] exp_q [$];
   logic [7:0] prev_data;
   bit         prev_stall;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the byte list a dump must produce, straight from memory.
   task automatic push_expected(input logic [AW-1:0] b, input int cnt);
      logic [AW-1:0] a;
      logic [DW-1:0] w;
      logic [7:0]    ck;
      a  = b;
      ck = 8'h00;
      for (int i = 0; i < cnt; i++) begin
         w = mem[a];
         exp_q.push_back(w[15:8]);
         exp_q.push_back(w[7:0]);
         ck = ck ^ w[15:8] ^ w[7:0];
         a  = a + 16'd1;
      end
      if (CK_BYTES != 0) exp_q.push_back(ck);
   endtask

   function automatic logic ready_for(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return (cyc % 4) == 3;
         2:       return 1'($urandom_range(0, 1));
         3:       return cyc > 30;
         default: return 1'b1;
      endcase
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      exp_dones = done_cnt;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run_dump(input logic [AW-1:0] b, input int cnt, input int mode, input bit inject);
      int            cyc;
      bit            got;
      logic [AW-1:0] fa;
      push_expected(b, cnt);
      exp_dones++;
      base_addr    = b;
      word_count   = (AW+1)'(cnt);
      start        = 1'b1;
      bus.tx_ready = ready_for(mode, 0);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 40 * cnt + 60) begin
         @(posedge clk); #1;
         cyc++;
         start = 1'b0;
         if (inject && cyc == 3) begin
            // Must be ignored: the dump is still running.
            start      = 1'b1;
            base_addr  = 16'($urandom);
            word_count = 17'($urandom_range(1, 9));
         end
         bus.tx_ready = ready_for(mode, cyc);
         if (done) got = 1'b1;
      end
      start = 1'b0;
      check("done_seen", 32'(got), 32'd1);
      if (mode == 0) check("done_latency", 32'(cyc), 32'(cnt * (RL + 2) + 2 + CK_BYTES));
      @(negedge clk); #1;
      fa = b + 16'(cnt);
      check("done_count", 32'(done_cnt), 32'(exp_dones));
      check("busy_after", 32'(busy), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("final_addr", 32'(bus.ram_addr), 32'(fa));
      bus.tx_ready = 1'b1;
      if (!got) do_reset();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      bus.tx_ready = 1'b1;
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_tx_send", 32'(bus.tx_send), 32'd0);
      check("rst_tx_data", 32'(bus.tx_data), 32'd0);
      check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
      check("rst_ram_wren", 32'(bus.ram_wren), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      fork
         begin : monitor
            prev_stall = 1'b0;
            prev_data  = 8'h00;
            while (!stim_done) begin
               @(negedge clk);
               if (rst) begin
                  prev_stall = 1'b0;
               end else begin
                  if (prev_stall && bus.tx_send)
                     check("tx_hold", 32'(bus.tx_data), 32'(prev_data));
                  if (bus.tx_send) check("busy_while_send", 32'(busy), 32'd1);
                  if (bus.tx_send && bus.tx_ready) begin
                     if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_byte: got 0x%0h expected no byte at %0t", bus.tx_data, $time);
                     end else begin
                        check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                     end
                  end
                  if (done) begin
                     done_cnt++;
                     check("busy_at_done", 32'(busy), 32'd0);
                  end
                  prev_stall = bus.tx_send && !bus.tx_ready;
                  prev_data  = bus.tx_data;
               end
            end
         end
         begin : stimulus
            // Basic dump, then the same under 3-low/1-high back-pressure.
            mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0004; mem[3] = 16'h0007;
            run_dump(16'h0000, 4, 0, 1'b0);
            run_dump(16'h0000, 4, 1, 1'b0);
            // Address wrap at the top of memory.
            mem[16'hFFFE] = 16'hA55A; mem[16'hFFFF] = 16'h1234; mem[16'h0000] = 16'hBEEF;
            run_dump(16'hFFFE, 3, 0, 1'b0);
            // Empty dump.
            run_dump(16'h0040, 0, 0, 1'b0);
            // Checksum pattern words.
            mem[16'h0100] = 16'h0102; mem[16'h0101] = 16'h0304;
            run_dump(16'h0100, 2, 0, 1'b0);
            // Long tx_ready stall plus an ignored start.
            run_dump(16'h2000, 2, 3, 1'b1);

            // Reset while the low byte of the first word is pending.
            push_expected(16'h0010, 4);
            base_addr  = 16'h0010;
            word_count = 17'd4;
            start      = 1'b1;
            bus.tx_ready = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (3) begin
               @(posedge clk); #1;
            end
            rst = 1'b1;
            #1;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            check("abort_tx_send", 32'(bus.tx_send), 32'd0);
            check("abort_tx_data", 32'(bus.tx_data), 32'd0);
            check("abort_ram_addr", 32'(bus.ram_addr), 32'd0);
            exp_q.delete();
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (3) begin
               @(posedge clk); #1;
            end
            check("abort_no_done", 32'(done_cnt), 32'(exp_dones));
            run_dump(16'h0010, 4, 0, 1'b0);

            // Randomised dumps.
            for (int k = 0; k < 12; k++) begin
               int c;
               c = $urandom_range(0, 6);
               run_dump(16'($urandom), c, $urandom_range(0, 2), (c > 0) && ($urandom_range(0, 1) == 1));
            end
            stim_done = 1'b1;
         end
      join

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
